reg_writeback_queue: RTL

- Write-side master for the 8-entry × 8-bit CPU register file.
- Accepts results from the memory (load) path and the ALU path, each with a valid/ready handshake, and queues them in acceptance order.
- Drains the queue one write per cycle onto the register file's single write port (RegWrite / EscReg / WriteData).
- Exports a pending-write mask so hazard logic can stall reads of registers with writes still in flight.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/reg_writeback_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue entry type for the register write-back path
package wb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - dual-push, single-pop circular buffer with a per-entry dest view
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push0_i,
  input  wb_entry_t                     push0_entry_i,
  input  logic                          push1_i,
  input  wb_entry_t                     push1_entry_i,
  input  logic                          pop_i,
  output wb_entry_t                     head_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_dest_o
);

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   wr1;
  logic [CNT_W-1:0]   count_q, count_d;

  // push1 lands directly behind push0, or in push0's slot when push0 is idle
  always_comb begin
    mem_d = mem_q;
    wr1   = wr_q + PTR_W'(push0_i);
    if (push0_i) mem_d[wr_q] = push0_entry_i;
    if (push1_i) mem_d[wr1]  = push1_entry_i;
    wr_d    = wr1 + PTR_W'(push1_i);
    rd_d    = rd_q + PTR_W'(pop_i);
    count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [PTR_W-1:0] offs;
    assign offs             = PTR_W'(i) - rd_q;
    assign entry_valid_o[i] = {1'b0, offs} < count_q;
    assign entry_dest_o[i]  = mem_q[i].dest;
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - merges load and ALU results into ordered register-file writes
module reg_writeback_queue #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_dest,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_dest,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       EscReg,
  output logic [DATA_W-1:0]       WriteData,
  output logic [(2**ADDR_W)-1:0]  pending,
  output logic [CNT_W-1:0]        count
);

  wb_pkg::wb_entry_t            mem_entry, alu_entry, head;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_dest;
  logic                         push_mem, push_alu, pop;
  logic                         regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]            escreg_q, escreg_d;
  logic [DATA_W-1:0]            wdata_q, wdata_d;

  // ALU needs two free slots so a same-cycle load can never starve it of space
  assign mem_ready = reset_n && (count < CNT_W'(DEPTH));
  assign alu_ready = reset_n && (count < CNT_W'(DEPTH - 1));

  assign push_mem  = mem_valid && mem_ready && (mem_dest != '0);
  assign push_alu  = alu_valid && alu_ready && (alu_dest != '0);
  assign pop       = (count != '0);
  assign mem_entry = '{dest: mem_dest, data: mem_data};
  assign alu_entry = '{dest: alu_dest, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .push0_i       (push_mem),
    .push0_entry_i (mem_entry),
    .push1_i       (push_alu),
    .push1_entry_i (alu_entry),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (count),
    .entry_valid_o (entry_valid),
    .entry_dest_o  (entry_dest)
  );

  always_comb begin
    regwrite_d = pop;
    escreg_d   = escreg_q;
    wdata_d    = wdata_q;
    if (pop) begin
      escreg_d = head.dest;
      wdata_d  = head.data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q <= 1'b0;
      escreg_q   <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      escreg_q   <= escreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign EscReg    = escreg_q;
  assign WriteData = wdata_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending[entry_dest[i]] = 1'b1;
    end
    if (regwrite_q) pending[escreg_q] = 1'b1;
  end

endmodule
